regfile_preloader: RTL and testbench
====================================

REGFILE_PRELOADER -- requirements
Module: regfile_preloader

Interface
REQ-001 SHALL have parameter: RUN_W, 16, width of the run-cycle budget.
REQ-002 SHALL have ports (clock and reset first):
  clock  input  1  single clock for all state; rising edge active
  reset  input  1  asynchronous, active-low reset
  start  input  1  one-cycle pulse; begins a preload/run session
  run_cycles  input  RUN_W  processor run budget, sampled on accepted start
  load_valid  input  1  preload entry present
  load_ready  output  1  preloader accepts entry this cycle
  load_reg  input  5  destination register index
  load_data  input  32  value to write
  load_last  input  1  marks final preload entry
  test  output  1  selects processor register-file test port
  t_ctrl_writeEnable  output  1  test-port write strobe
  t_ctrl_writeReg  output  5  test-port write index
  t_data_writeReg  output  32  test-port write data
  proc_reset  output  1  holds processor in reset (active-high)
  busy  output  1  session in progress
  run_done  output  1  budget expired; register file ready for readback
  err_r0  output  1  sticky: a preload targeted register 0

Function
REQ-003 SHALL implement states IDLE, LOAD, SETTLE, RUN, DONE.
REQ-004 IDLE: proc_reset=1, test=0, busy=0, load_ready=0; start -> LOAD, latch run_cycles.
REQ-005 LOAD: test=1, proc_reset=1, busy=1, load_ready=1; handshake = load_valid && load_ready, at most one entry per cycle.
REQ-006 Each accepted entry with load_reg!=0 SHALL drive t_ctrl_writeEnable=1, t_ctrl_writeReg=load_reg, t_data_writeReg=load_data in the cycle after the handshake (registered, latency 1).
REQ-007 Entry with load_reg==0 SHALL be consumed with no write strobe and SHALL set err_r0.
REQ-008 Accepted entry with load_last=1 SHALL move LOAD -> SETTLE; load_ready=0 from the next cycle.
REQ-009 SETTLE lasts exactly one cycle (final write strobe issues here), test=1, proc_reset=1; then -> RUN, or -> DONE if latched run_cycles==0.
REQ-010 RUN: test=0, proc_reset=0, t_ctrl_writeEnable=0; counter counts from 0; after exactly run_cycles RUN cycles -> DONE.
REQ-011 DONE: run_done=1, test=1, proc_reset=0, t_ctrl_writeEnable=0, busy=0; processor state frozen for readback via test port.
REQ-012 start SHALL be honoured only in IDLE or DONE (-> LOAD, clears run_done and err_r0); ignored in LOAD, SETTLE, RUN.
REQ-013 load_valid outside LOAD SHALL be ignored (load_ready=0, no write).
REQ-014 t_ctrl_writeEnable SHALL never assert outside LOAD/SETTLE; write index/data hold last value when strobe low.
REQ-015 Counter width RUN_W; run_cycles=2^RUN_W-1 SHALL run full budget with no wrap before DONE.

Reset
REQ-016 reset low SHALL asynchronously force IDLE: proc_reset=1, all other outputs 0, counter 0, t_ctrl_writeReg=0, t_data_writeReg=0.
REQ-017 reset mid-LOAD or mid-RUN SHALL abort the session; pending write strobe SHALL not issue; release returns to IDLE awaiting start.

Structure
REQ-018 Shared package SHALL hold state encoding, REG_ADDR_W=5, DATA_W=32.
REQ-019 SHALL instantiate one sub-module run_counter (RUN_W-bit clear/enable counter with terminal-count output).

Verification
REQ-020 start, run_cycles=10, entries (3,42),(6,80 last) -> strobes reg3=42 then reg6=80 on consecutive cycles, RUN 10 cycles, run_done=1.
REQ-021 entries (0,5),(9,4 last) -> no strobe for reg0, err_r0=1, reg9=4 written, session completes.
REQ-022 run_cycles=0, single entry (12,7 last) -> SETTLE then DONE directly, proc_reset never deasserts before DONE.
REQ-023 load_valid toggled 1/0/1 with 3 entries -> exactly 3 strobes, none on idle cycles.
REQ-024 reset low during RUN cycle 5 -> immediate IDLE outputs; start afterward runs a fresh session correctly.
REQ-025 start pulsed during RUN -> ignored; DONE at original cycle count; start in DONE clears run_done and err_r0.

Source files
------------

// File: rtl/regfile_preloader_pkg.sv
// -----------------------------------------------------------------------------
// regfile_preloader_pkg
// Shared definitions for the register-file preloader: processor register-file
// geometry, the session state encoding and the per-state control-output bundle.
// -----------------------------------------------------------------------------
package regfile_preloader_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      SETTLE = 3'd2,
      RUN    = 3'd3,
      DONE   = 3'd4
   } state_e;

   // Control outputs that depend only on the session state.
   typedef struct packed {
      logic test;
      logic proc_reset;
      logic busy;
      logic load_ready;
      logic run_done;
   } ctrl_t;

   // Output levels the session presents while sitting in state s.
   function automatic ctrl_t state_ctrl(input state_e s);
      ctrl_t c;
      c = '{test: 1'b0, proc_reset: 1'b1, busy: 1'b0, load_ready: 1'b0, run_done: 1'b0};
      case (s)
         LOAD:    c = '{test: 1'b1, proc_reset: 1'b1, busy: 1'b1, load_ready: 1'b1, run_done: 1'b0};
         SETTLE:  c = '{test: 1'b1, proc_reset: 1'b1, busy: 1'b1, load_ready: 1'b0, run_done: 1'b0};
         RUN:     c = '{test: 1'b0, proc_reset: 1'b0, busy: 1'b1, load_ready: 1'b0, run_done: 1'b0};
         DONE:    c = '{test: 1'b1, proc_reset: 1'b0, busy: 1'b0, load_ready: 1'b0, run_done: 1'b1};
         default: c = '{test: 1'b0, proc_reset: 1'b1, busy: 1'b0, load_ready: 1'b0, run_done: 1'b0};
      endcase
      return c;
   endfunction

endpackage

// File: rtl/regfile_preloader_run_counter.sv
// -----------------------------------------------------------------------------
// run_counter
// RUN_W-bit up-counter with synchronous clear and enable. tc_o is high while
// the count equals terminal_i, letting the owner stop after terminal_i+1
// enabled cycles without ever wrapping.
//   clock, reset  : clock, asynchronous active-low reset
//   clear_i       : force count to zero (wins over enable_i)
//   enable_i      : advance count by one
//   terminal_i    : count value that marks the final enabled cycle
//   tc_o          : count == terminal_i
// -----------------------------------------------------------------------------
module run_counter #(
   parameter int RUN_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear_i,
   input  logic             enable_i,
   input  logic [RUN_W-1:0] terminal_i,
   output logic             tc_o
);

   logic [RUN_W-1:0] count_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else if (clear_i) begin
         count_q <= '0;
      end else if (enable_i) begin
         count_q <= count_q + {{(RUN_W-1){1'b0}}, 1'b1};
      end
   end

   assign tc_o = (count_q == terminal_i);

endmodule

// File: rtl/regfile_preloader.sv
// -----------------------------------------------------------------------------
// regfile_preloader
// Preloads a processor register file through its test port, releases the
// processor from reset for a fixed cycle budget, then freezes it with the test
// port selected so the register file can be read back.
//   clock, reset          : clock, asynchronous active-low reset
//   start, run_cycles     : session launch pulse and run budget (latched)
//   load_valid/ready/reg/data/last : preload entry handshake
//   test                  : selects the processor register-file test port
//   t_ctrl_writeEnable, t_ctrl_writeReg, t_data_writeReg : test-port write
//   proc_reset            : holds the processor in reset (active high)
//   busy, run_done        : session in progress / budget expired
//   err_r0                : sticky, a preload entry targeted register 0
// -----------------------------------------------------------------------------
module regfile_preloader
   import regfile_preloader_pkg::*;
#(
   parameter int RUN_W = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [RUN_W-1:0]      run_cycles,
   input  logic                  load_valid,
   output logic                  load_ready,
   input  logic [REG_ADDR_W-1:0] load_reg,
   input  logic [DATA_W-1:0]     load_data,
   input  logic                  load_last,
   output logic                  test,
   output logic                  t_ctrl_writeEnable,
   output logic [REG_ADDR_W-1:0] t_ctrl_writeReg,
   output logic [DATA_W-1:0]     t_data_writeReg,
   output logic                  proc_reset,
   output logic                  busy,
   output logic                  run_done,
   output logic                  err_r0
);

   localparam logic [RUN_W-1:0] RUN_ONE = {{(RUN_W-1){1'b0}}, 1'b1};

   state_e                state_q, state_d;
   ctrl_t                 ctrl_q;
   logic [RUN_W-1:0]      run_q;
   logic                  we_q;
   logic [REG_ADDR_W-1:0] wreg_q;
   logic [DATA_W-1:0]     wdata_q;
   logic                  err_q;
   logic                  run_tc;
   logic                  handshake;
   logic                  start_ok;
   logic                  write_ok;

   // load_ready is a registered decode of LOAD, so the handshake is only
   // possible while loading.
   assign handshake = load_valid && ctrl_q.load_ready;
   assign start_ok  = start && ((state_q == IDLE) || (state_q == DONE));
   assign write_ok  = handshake && (load_reg != '0);

   // NOTE: combinational blocks assign a default first so no path can leave a
   // signal unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: if (start) state_d = LOAD;
         LOAD:       if (handshake && load_last) state_d = SETTLE;
         SETTLE:     state_d = (run_q == '0) ? DONE : RUN;
         RUN:        if (run_tc) state_d = DONE;
         default:    state_d = IDLE;
      endcase
   end

   // NOTE: every register below is assigned with <= so all state updates see
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         ctrl_q  <= state_ctrl(IDLE);
         run_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         // Outputs are registered alongside the state they belong to.
         ctrl_q  <= state_ctrl(state_d);
         if (start_ok) begin
            run_q <= run_cycles;
         end
         if (start_ok) begin
            err_q <= 1'b0;
         end else if (handshake && (load_reg == '0)) begin
            err_q <= 1'b1;
         end
      end
   end

   // Test-port write pipeline: one-cycle strobe after each accepted entry;
   // index and data hold their last value while the strobe is low. Reset
   // clears the strobe, so a write pending at reset never issues.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         we_q    <= 1'b0;
         wreg_q  <= '0;
         wdata_q <= '0;
      end else begin
         we_q <= write_ok;
         if (write_ok) begin
            wreg_q  <= load_reg;
            wdata_q <= load_data;
         end
      end
   end

   // Counter sits at zero outside RUN and stops at run_q-1, so RUN lasts
   // exactly run_q cycles; run_q is never zero while in RUN.
   run_counter #(
      .RUN_W (RUN_W)
   ) u_run_counter (
      .clock      (clock),
      .reset      (reset),
      .clear_i    (state_q != RUN),
      .enable_i   (state_q == RUN),
      .terminal_i (run_q - RUN_ONE),
      .tc_o       (run_tc)
   );

   assign load_ready         = ctrl_q.load_ready;
   assign test               = ctrl_q.test;
   assign proc_reset         = ctrl_q.proc_reset;
   assign busy               = ctrl_q.busy;
   assign run_done           = ctrl_q.run_done;
   assign t_ctrl_writeEnable = we_q;
   assign t_ctrl_writeReg    = wreg_q;
   assign t_data_writeReg    = wdata_q;
   assign err_r0             = err_q;

endmodule

// File: tb/tb_regfile_preloader.sv
// -----------------------------------------------------------------------------
// tb_regfile_preloader
// Self-checking bench. A session is modelled as a timeline: LOAD starts the
// cycle after start, each accepted entry strobes one cycle later, SETTLE
// follows the last entry, then N RUN cycles, then DONE.
// -----------------------------------------------------------------------------
module tb_regfile_preloader;

   localparam int TB_RUN_W = 4;

   logic                clock = 1'b0;
   logic                reset = 1'b0;
   logic                start = 1'b0;
   logic [TB_RUN_W-1:0] run_cycles = '0;
   logic                load_valid = 1'b0;
   logic                load_ready;
   logic [4:0]          load_reg = '0;
   logic [31:0]         load_data = '0;
   logic                load_last = 1'b0;
   logic                test;
   logic                t_ctrl_writeEnable;
   logic [4:0]          t_ctrl_writeReg;
   logic [31:0]         t_data_writeReg;
   logic                proc_reset;
   logic                busy;
   logic                run_done;
   logic                err_r0;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state: last value written through the test port.
   logic [4:0]  exp_wreg  = '0;
   logic [31:0] exp_wdata = '0;

   // Entries for the next session.
   logic [4:0]  ent_reg[$];
   logic [31:0] ent_data[$];

   regfile_preloader #(.RUN_W(TB_RUN_W)) dut (
      .clock              (clock),
      .reset              (reset),
      .start              (start),
      .run_cycles         (run_cycles),
      .load_valid         (load_valid),
      .load_ready         (load_ready),
      .load_reg           (load_reg),
      .load_data          (load_data),
      .load_last          (load_last),
      .test               (test),
      .t_ctrl_writeEnable (t_ctrl_writeEnable),
      .t_ctrl_writeReg    (t_ctrl_writeReg),
      .t_data_writeReg    (t_data_writeReg),
      .proc_reset         (proc_reset),
      .busy               (busy),
      .run_done           (run_done),
      .err_r0             (err_r0)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic add_entry(input int r, input int d);
      ent_reg.push_back(r[4:0]);
      ent_data.push_back(d[31:0]);
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".proc_reset"}, proc_reset, 1);
      check({tag, ".test"}, test, 0);
      check({tag, ".busy"}, busy, 0);
      check({tag, ".load_ready"}, load_ready, 0);
      check({tag, ".run_done"}, run_done, 0);
      check({tag, ".we"}, t_ctrl_writeEnable, 0);
      check({tag, ".err_r0"}, err_r0, 0);
      check({tag, ".wreg"}, t_ctrl_writeReg, exp_wreg);
      check({tag, ".wdata"}, t_data_writeReg, exp_wdata);
   endtask

   // Reset while in the current state; outputs must go to idle values at once.
   task automatic apply_reset(input string tag);
      reset = 1'b0;
      #1;
      exp_wreg  = '0;
      exp_wdata = '0;
      check_idle({tag, ".async"});
      step();
      check_idle({tag, ".held"});
      reset = 1'b1;
      load_valid = 1'b1;
      load_reg = 5'd11;
      step();
      check_idle({tag, ".released"});
      load_valid = 1'b0;
   endtask

   // vmode: 0 valid every cycle, 1 alternate 1/0/1, 2 random.
   // start_at / reset_at: RUN cycle index for a stray start / a reset (-1 none).
   task automatic session(input int n_run, input int vmode, input int start_at, input int reset_at);
      int  n;
      int  idx;
      int  cyc;
      bit  v;
      bit  exp_we;
      bit  exp_err;
      n = ent_reg.size();
      idx = 0;
      cyc = 0;
      exp_err = 1'b0;
      start = 1'b1;
      run_cycles = n_run[TB_RUN_W-1:0];
      load_valid = 1'b0;
      step();
      start = 1'b0;
      check("start.load_ready", load_ready, 1);
      check("start.busy", busy, 1);
      check("start.test", test, 1);
      check("start.proc_reset", proc_reset, 1);
      check("start.run_done", run_done, 0);
      check("start.err_r0", err_r0, 0);

      while (idx < n && cyc < 64) begin
         case (vmode)
            0:       v = 1'b1;
            1:       v = (cyc % 2 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         load_valid = v;
         load_reg   = v ? ent_reg[idx] : 5'($urandom_range(1, 31));
         load_data  = v ? ent_data[idx] : $urandom;
         load_last  = v ? (idx == n - 1) : 1'b1;
         step();
         cyc++;
         exp_we = 1'b0;
         if (v) begin
            if (ent_reg[idx] != 0) begin
               exp_we    = 1'b1;
               exp_wreg  = ent_reg[idx];
               exp_wdata = ent_data[idx];
            end else begin
               exp_err = 1'b1;
            end
            idx++;
         end
         check("load.we", t_ctrl_writeEnable, exp_we);
         check("load.wreg", t_ctrl_writeReg, exp_wreg);
         check("load.wdata", t_data_writeReg, exp_wdata);
         check("load.err_r0", err_r0, exp_err);
         if (idx < n) begin
            check("load.load_ready", load_ready, 1);
         end else begin
            check("settle.load_ready", load_ready, 0);
            check("settle.test", test, 1);
            check("settle.proc_reset", proc_reset, 1);
            check("settle.busy", busy, 1);
         end
      end
      check("load.entries_accepted", idx, n);

      for (int i = 0; i < n_run; i++) begin
         load_valid = 1'b1;
         load_reg   = 5'd17;
         load_data  = $urandom;
         load_last  = 1'b1;
         if (i == start_at) begin
            start = 1'b1;
            run_cycles = '0;
         end
         step();
         start = 1'b0;
         check("run.test", test, 0);
         check("run.proc_reset", proc_reset, 0);
         check("run.busy", busy, 1);
         check("run.run_done", run_done, 0);
         check("run.we", t_ctrl_writeEnable, 0);
         check("run.load_ready", load_ready, 0);
         check("run.wreg_hold", t_ctrl_writeReg, exp_wreg);
         if (i == reset_at) begin
            #2;
            apply_reset("run_reset");
            ent_reg.delete();
            ent_data.delete();
            return;
         end
      end

      load_valid = 1'b0;
      step();
      check("done.run_done", run_done, 1);
      check("done.test", test, 1);
      check("done.proc_reset", proc_reset, 0);
      check("done.busy", busy, 0);
      check("done.we", t_ctrl_writeEnable, 0);
      check("done.load_ready", load_ready, 0);
      check("done.err_r0", err_r0, exp_err);
      check("done.wreg", t_ctrl_writeReg, exp_wreg);
      check("done.wdata", t_data_writeReg, exp_wdata);

      // Stray entry while frozen: nothing is written.
      load_valid = 1'b1;
      load_reg   = 5'd9;
      step();
      check("done_hold.we", t_ctrl_writeEnable, 0);
      check("done_hold.run_done", run_done, 1);
      load_valid = 1'b0;
      ent_reg.delete();
      ent_data.delete();
   endtask

   initial begin
      int n_ent;
      // Power-on reset, then idle with a stray entry.
      repeat (2) step();
      check_idle("por");
      reset = 1'b1;
      load_valid = 1'b1;
      load_reg = 5'd4;
      load_data = 32'h1234;
      step();
      check_idle("idle_stray");
      load_valid = 1'b0;

      // Basic two-entry preload, 10-cycle run.
      add_entry(3, 42);
      add_entry(6, 80);
      session(10, 0, -1, -1);

      // Register-0 entry: consumed silently, error flagged.
      add_entry(0, 5);
      add_entry(9, 4);
      session(3, 0, -1, -1);

      // Zero budget: SETTLE straight to DONE.
      add_entry(12, 7);
      session(0, 0, -1, -1);

      // Gapped valid.
      add_entry(1, 32'hAAAA_0001);
      add_entry(2, 32'hAAAA_0002);
      add_entry(31, 32'hAAAA_001F);
      session(2, 1, -1, -1);

      // Reset during RUN, then a fresh session.
      add_entry(5, 55);
      session(8, 0, -1, 5);
      add_entry(7, 77);
      add_entry(8, 88);
      session(4, 0, -1, -1);

      // Stray start during RUN; the following start clears run_done/err_r0.
      add_entry(0, 1);
      add_entry(2, 3);
      session(6, 0, 2, -1);
      add_entry(4, 44);
      session(1, 0, -1, -1);

      // Full budget, no wrap.
      add_entry(30, 32'hDEAD_BEEF);
      session((1 << TB_RUN_W) - 1, 0, -1, -1);

      // Reset between handshake and its strobe: the write must not issue.
      start = 1'b1;
      run_cycles = 4'd3;
      step();
      start = 1'b0;
      load_valid = 1'b1;
      load_reg = 5'd13;
      load_data = 32'h0BAD_0BAD;
      load_last = 1'b1;
      #3;
      reset = 1'b0;
      exp_wreg  = '0;
      exp_wdata = '0;
      @(posedge clock);
      #1;
      check("pending.we", t_ctrl_writeEnable, 0);
      check("pending.wreg", t_ctrl_writeReg, 0);
      reset = 1'b1;
      load_valid = 1'b0;
      step();
      check_idle("pending.idle");

      // Randomised sessions.
      for (int s = 0; s < 8; s++) begin
         n_ent = $urandom_range(1, 5);
         for (int e = 0; e < n_ent; e++) begin
            add_entry(($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 31), $urandom);
         end
         session($urandom_range(0, (1 << TB_RUN_W) - 1), 2, -1, -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
